// File: rtl/freq_measure_sequencer.sv
// ============================================================================
// Module   : freq_measure_sequencer
// Purpose  : Gate-window edge counter with BCD tens/units split for the
//            frequency-counter display path. Optional macro
//            FREQ_SEQ_ONESHOT_EN adds a start port and an IDLE wait state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_measure_sequencer #(
  parameter int                   PERIOD_W       = 12,
  parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = 12'd1000,
  parameter int                   MAX_COUNT      = 99
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal_edge,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                load_period,
`ifdef FREQ_SEQ_ONESHOT_EN
  input  logic                start,
`endif
  output logic [3:0]          tens,
  output logic [3:0]          units,
  output logic                result_valid,
  output logic                overflow,
  output logic [1:0]          dbg_state,
  output logic [2:0]          dbg_clk_count,
  output logic [2:0]          dbg_edge_count
);

  localparam int               CNT_W   = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] C_TEN   = CNT_W'(10);

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_TENS  = 2'd1,
    ST_UNITS = 2'd2,
    ST_IDLE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] win_len_q;
  logic [PERIOD_W-1:0] clk_count_q;
  logic [CNT_W-1:0]    edge_count_q;
  logic [CNT_W-1:0]    edge_count_d;
  logic                sat_q;
  logic                sat_d;
  logic [CNT_W-1:0]    work_q;
  logic [3:0]          tens_acc_q;
  logic [3:0]          tens_q;
  logic [3:0]          units_q;
  logic                valid_q;
  logic                overflow_q;
  logic                last_cycle;

  // Saturating edge count including this cycle's edge, so the final
  // cycle of the window is captured into work_q on the window-end edge.
  always_comb begin
    edge_count_d = edge_count_q;
    sat_d        = sat_q;
    if (signal_edge) begin
      if (edge_count_q == C_MAX) begin
        sat_d = 1'b1;
      end else begin
        edge_count_d = edge_count_q + CNT_W'(1);
      end
    end
  end

  assign last_cycle = (clk_count_q == (win_len_q - PERIOD_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef FREQ_SEQ_ONESHOT_EN
      state_q      <= ST_IDLE;
`else
      state_q      <= ST_COUNT;
`endif
      period_q     <= DEFAULT_PERIOD;
      win_len_q    <= DEFAULT_PERIOD;
      clk_count_q  <= '0;
      edge_count_q <= '0;
      sat_q        <= 1'b0;
      work_q       <= '0;
      tens_acc_q   <= '0;
      tens_q       <= '0;
      units_q      <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load_period && (period_in != '0)) begin
        period_q <= period_in;
      end

      case (state_q)
        ST_COUNT: begin
          edge_count_q <= edge_count_d;
          sat_q        <= sat_d;
          if (last_cycle) begin
            state_q     <= ST_TENS;
            work_q      <= edge_count_d;
            tens_acc_q  <= '0;
            clk_count_q <= '0;
          end else begin
            clk_count_q <= clk_count_q + PERIOD_W'(1);
          end
        end

        // Repeated subtraction: one cycle per tens digit plus one exit cycle.
        ST_TENS: begin
          if (work_q >= C_TEN) begin
            work_q     <= work_q - C_TEN;
            tens_acc_q <= tens_acc_q + 4'd1;
          end else begin
            state_q <= ST_UNITS;
          end
        end

        ST_UNITS: begin
          tens_q       <= tens_acc_q;
          units_q      <= work_q[3:0];
          overflow_q   <= sat_q;
          valid_q      <= 1'b1;
          edge_count_q <= '0;
          sat_q        <= 1'b0;
          win_len_q    <= period_q;
`ifdef FREQ_SEQ_ONESHOT_EN
          state_q      <= ST_IDLE;
`else
          state_q      <= ST_COUNT;
`endif
        end

`ifdef FREQ_SEQ_ONESHOT_EN
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_COUNT;
            win_len_q <= period_q;
          end
        end
`endif

        default: state_q <= ST_COUNT;
      endcase
    end
  end

  assign tens           = tens_q;
  assign units          = units_q;
  assign result_valid   = valid_q;
  assign overflow       = overflow_q;
  assign dbg_state      = state_q;
  assign dbg_clk_count  = clk_count_q[2:0];
  assign dbg_edge_count = edge_count_q[2:0];

endmodule

`default_nettype wire

// File: tb/tb_freq_measure_sequencer.sv
// Scoreboard bench for freq_measure_sequencer: windows are driven with a known
// edge plan, the expected digits and arrival cycle are queued and matched on result_valid.
`timescale 1ns/1ps
`default_nettype none

module tb_freq_measure_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_edge = 1'b0;
  logic        load_period = 1'b0;
  logic        start = 1'b0;
  logic [11:0] period_in = 12'd0;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        result_valid;
  logic        overflow;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_clk_count;
  logic [2:0]  dbg_edge_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int prev_tens = 0;
  int prev_units = 0;

  typedef struct {
    int tens;
    int units;
    int ovf;
    int at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  freq_measure_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .signal_edge    (signal_edge),
    .period_in      (period_in),
    .load_period    (load_period),
`ifdef FREQ_SEQ_ONESHOT_EN
    .start          (start),
`endif
    .tens           (tens),
    .units          (units),
    .result_valid   (result_valid),
    .overflow       (overflow),
    .dbg_state      (dbg_state),
    .dbg_clk_count  (dbg_clk_count),
    .dbg_edge_count (dbg_edge_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("tens", int'(tens), mon_e.tens);
        check("units", int'(units), mon_e.units);
        check("overflow", int'(overflow), mon_e.ovf);
        check("valid_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic do_reset;
    reset       = 1'b1;
    signal_edge = 1'b0;
    load_period = 1'b0;
    start       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    prev_tens  = 0;
    prev_units = 0;
  endtask

  // Called at COUNT cycle 0; returns at the next window's cycle 0.
  task automatic run_window(input int len, input int first, input int step, input int nmax,
                            input int load_at, input logic [11:0] load_val);
    int   n;
    int   cnt;
    int   ws;
    exp_t e;
    n  = 0;
    ws = cyc;
    for (int i = 0; i < len; i++) begin
      if (i == 3) begin
        check("clk_count", int'(dbg_clk_count), 3);
        check("state_count", int'(dbg_state), 0);
        check("hold_tens", int'(tens), prev_tens);
        check("hold_units", int'(units), prev_units);
      end
      if (i == len - 1) check("edge_count", int'(dbg_edge_count), ((n > 99) ? 99 : n) & 7);
      signal_edge = (n < nmax) && (i >= first) && (((i - first) % step) == 0);
      if (signal_edge) n++;
      load_period = (i == load_at);
      period_in   = load_val;
      @(posedge clk);
      #1;
    end
    load_period = 1'b0;
    cnt     = (n > 99) ? 99 : n;
    e.tens  = cnt / 10;
    e.units = cnt % 10;
    e.ovf   = (n > 99) ? 1 : 0;
    e.at    = ws + len + cnt / 10 + 2;
    sb_q.push_back(e);
    prev_tens  = e.tens;
    prev_units = e.units;
    // Dead time: edges here must be ignored.
    for (int j = 0; j < cnt / 10 + 2; j++) begin
      signal_edge = 1'b1;
      @(posedge clk);
      #1;
    end
    signal_edge = 1'b0;
  endtask

  initial begin
    do_reset();
`ifdef FREQ_SEQ_ONESHOT_EN
    check("rst_state_idle", int'(dbg_state), 3);
    check("rst_tens", int'(tens), 0);
    check("rst_units", int'(units), 0);
    period_in   = 12'd20;
    load_period = 1'b1;
    @(posedge clk); #1;
    load_period = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_start", int'(dbg_state), 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_window(20, 0, 1, 13, -1, 12'd0);
    check("back_to_idle", int'(dbg_state), 3);
    repeat (30) @(posedge clk);
    #1;
    check("still_idle", int'(dbg_state), 3);
`else
    check("rst_state", int'(dbg_state), 0);
    check("rst_clk_count", int'(dbg_clk_count), 0);
    check("rst_edge_count", int'(dbg_edge_count), 0);
    check("rst_tens", int'(tens), 0);
    check("rst_units", int'(units), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_valid", int'(result_valid), 0);

    for (int i = 0; i < 10; i++) begin
      signal_edge = (i % 2 == 0);
      @(posedge clk); #1;
    end
    signal_edge = 1'b0;
    check("mid_edge_count", int'(dbg_edge_count), 5);
    do_reset();
    check("rst2_state", int'(dbg_state), 0);
    check("rst2_edge_count", int'(dbg_edge_count), 0);
    check("rst2_clk_count", int'(dbg_clk_count), 0);
    check("rst2_tens", int'(tens), 0);
    check("rst2_units", int'(units), 0);

    run_window(1000, 100, 100, 3, 5, 12'd20);
    run_window(20, 0, 3, 7, 4, 12'd0);
    run_window(20, 0, 1, 12, 10, 12'd50);
    run_window(50, 0, 1, 50, 49, 12'd100);
    run_window(100, 17, 2, 42, -1, 12'd0);
    run_window(100, 1, 1, 99, 30, 12'd300);
    run_window(300, 0, 2, 150, 30, 12'd20);
    run_window(20, 0, 1, 0, -1, 12'd0);
    repeat (5) @(posedge clk);
    #1;
`endif
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
